// File: rtl/ahb_lite_pkg.sv
// Shared types for the AHB-Lite matrix.
// Contents:
//   htrans_e     - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_e      - HRESP encodings (OKAY/ERROR)
//   def_state_e  - default-subordinate FSM states
//   dec_t        - decode result: hit flag plus subordinate index (hit==0 is DEFAULT)
//   ahb_decode() - masked region compare, lowest index wins on overlap
package ahb_lite_pkg;

    // The decode function works on fixed maximum widths; callers zero-extend into these.
    localparam int MAX_SUBS = 16;
    localparam int MAX_AW   = 64;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RespOkay  = 2'b00,
        RespError = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        StIdle,
        StErr1,
        StErr2
    } def_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } dec_t;

    // Walk from the top index down so the lowest matching index is the one left standing.
    function automatic dec_t ahb_decode(
        input logic [MAX_AW-1:0]          addr,
        input logic [MAX_SUBS*MAX_AW-1:0] base,
        input logic [MAX_SUBS*MAX_AW-1:0] mask,
        input int                         n_subs
    );
        dec_t d;
        d.hit = 1'b0;
        d.idx = 4'd0;
        for (int i = MAX_SUBS - 1; i >= 0; i--) begin
            if (i < n_subs &&
                (addr & mask[i*MAX_AW +: MAX_AW]) == base[i*MAX_AW +: MAX_AW]) begin
                d.hit = 1'b1;
                d.idx = i[3:0];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ahb_lite_matrix_if.sv
// Bus bundle between one AHB-Lite manager, the matrix and its subordinates.
// Signals:
//   HADDR/HTRANS/HWRITE          manager address phase
//   HSEL_S/HREADY_S              matrix -> subordinates
//   HRDATA_S/HRESP_S/HREADYOUT_S subordinates -> matrix (packed, index 0 in LSBs)
//   HRDATA/HRESP/HREADY          matrix -> manager
// Modports:
//   slave  - the matrix's view (consumes manager and subordinate outputs)
//   master - the environment's view (manager plus subordinates)
interface ahb_lite_matrix_if #(
    parameter int unsigned NO_OF_SUBORDINATES = 4,
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned DATA_WIDTH         = 32
);
    logic [ADDR_WIDTH-1:0]                    HADDR;
    logic [1:0]                               HTRANS;
    logic                                     HWRITE;
    logic [NO_OF_SUBORDINATES-1:0]            HSEL_S;
    logic                                     HREADY_S;
    logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S;
    logic [NO_OF_SUBORDINATES*2-1:0]          HRESP_S;
    logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S;
    logic [DATA_WIDTH-1:0]                    HRDATA;
    logic [1:0]                               HRESP;
    logic                                     HREADY;

    modport slave (
        input  HADDR, HTRANS, HWRITE, HRDATA_S, HRESP_S, HREADYOUT_S,
        output HSEL_S, HREADY_S, HRDATA, HRESP, HREADY
    );

    modport master (
        output HADDR, HTRANS, HWRITE, HRDATA_S, HRESP_S, HREADYOUT_S,
        input  HSEL_S, HREADY_S, HRDATA, HRESP, HREADY
    );
endinterface

// File: rtl/ahb_lite_default_sub.sv
// Default subordinate: answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR
// response (ERR1: not ready + ERROR, ERR2: ready + ERROR). Outputs are registered.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   hready        bus HREADY (address phase accepted when high)
//   sel           address phase decodes to no subordinate
//   trans_active  HTRANS[1], i.e. NONSEQ or SEQ
//   ready_out     HREADYOUT of this subordinate
//   resp          HRESP of this subordinate
module ahb_lite_default_sub
    import ahb_lite_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hready,
    input  logic       sel,
    input  logic       trans_active,
    output logic       ready_out,
    output logic [1:0] resp
);

    def_state_e state_q;
    logic       ready_q;
    logic [1:0] resp_q;
    logic       start;

    assign start = hready && sel && trans_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            resp_q  <= RespOkay;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StErr1;
                        ready_q <= 1'b0;
                        resp_q  <= RespError;
                    end
                end
                StErr1: begin
                    state_q <= StErr2;
                    ready_q <= 1'b1;
                    resp_q  <= RespError;
                end
                StErr2: begin
                    if (start) begin
                        state_q <= StErr1;
                        ready_q <= 1'b0;
                        resp_q  <= RespError;
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        resp_q  <= RespOkay;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    resp_q  <= RespOkay;
                end
            endcase
        end
    end

    assign ready_out = ready_q;
    assign resp      = resp_q;

endmodule

// File: rtl/ahb_lite_matrix.sv
// Single-manager AHB-Lite interconnect: address decode, registered data-phase owner,
// response mux, integrated default subordinate and sticky error capture.
// Ports:
//   HCLK, HRESET  clock, asynchronous active-high reset
//   bus           ahb_lite_matrix_if.slave (manager + subordinate signals)
//   ERR_CLR       synchronous clear of the error capture registers
//   ERR_ADDR      address of the most recent errored transfer
//   ERR_WRITE     HWRITE of the most recent errored transfer
//   ERR_CNT       saturating count of ERROR completions
module ahb_lite_matrix
    import ahb_lite_pkg::*;
#(
    parameter int unsigned NO_OF_SUBORDINATES = 4,
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter logic [NO_OF_SUBORDINATES*ADDR_WIDTH-1:0] SUB_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NO_OF_SUBORDINATES*ADDR_WIDTH-1:0] SUB_MASK = {4{32'hF000_0000}},
    parameter int unsigned ERR_CNT_WIDTH      = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    ahb_lite_matrix_if.slave         bus,
    input  logic                     ERR_CLR,
    output logic [ADDR_WIDTH-1:0]    ERR_ADDR,
    output logic                     ERR_WRITE,
    output logic [ERR_CNT_WIDTH-1:0] ERR_CNT
);

    logic [MAX_SUBS*MAX_AW-1:0]    base_ext;
    logic [MAX_SUBS*MAX_AW-1:0]    mask_ext;
    dec_t                          dec;
    dec_t                          dsel_q;
    logic [NO_OF_SUBORDINATES-1:0] hsel;

    logic [DATA_WIDTH-1:0]         hrdata;
    logic [1:0]                    hresp;
    logic                          hready;
    logic                          def_ready;
    logic [1:0]                    def_resp;

    logic [ADDR_WIDTH-1:0]         haddr_q;
    logic                          hwrite_q;
    logic [ADDR_WIDTH-1:0]         err_addr_q;
    logic                          err_write_q;
    logic [ERR_CNT_WIDTH-1:0]      err_cnt_q;
    logic                          err_done;

    // Region table widened into the fixed-size slots the package decoder expects.
    always_comb begin
        base_ext = '0;
        mask_ext = '0;
        for (int i = 0; i < int'(NO_OF_SUBORDINATES); i++) begin
            base_ext[i*MAX_AW +: MAX_AW] = MAX_AW'(SUB_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]);
            mask_ext[i*MAX_AW +: MAX_AW] = MAX_AW'(SUB_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    assign dec = ahb_decode(MAX_AW'(bus.HADDR), base_ext, mask_ext, int'(NO_OF_SUBORDINATES));

    always_comb begin
        hsel = '0;
        for (int i = 0; i < int'(NO_OF_SUBORDINATES); i++) begin
            if (dec.hit && dec.idx == 4'(i)) begin
                hsel[i] = 1'b1;
            end
        end
    end

    ahb_lite_default_sub u_default_sub (
        .clk          (HCLK),
        .rst          (HRESET),
        .hready       (hready),
        .sel          (~dec.hit),
        .trans_active (bus.HTRANS[1]),
        .ready_out    (def_ready),
        .resp         (def_resp)
    );

    // Response mux keyed only on the registered owner, so HADDR never reaches HRDATA.
    always_comb begin
        hrdata = '0;
        hresp  = def_resp;
        hready = def_ready;
        if (dsel_q.hit) begin
            hresp  = RespOkay;
            hready = 1'b1;
            for (int i = 0; i < int'(NO_OF_SUBORDINATES); i++) begin
                if (dsel_q.idx == 4'(i)) begin
                    hrdata = bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                    hresp  = bus.HRESP_S[i*2 +: 2];
                    hready = bus.HREADYOUT_S[i];
                end
            end
        end
    end

    // Only the ready half of a two-cycle ERROR counts as a completion.
    assign err_done = hready && (hresp == RespError);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_q      <= '{hit: 1'b0, idx: 4'd0};
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (hready) begin
                dsel_q   <= dec;
                haddr_q  <= bus.HADDR;
                hwrite_q <= bus.HWRITE;
            end
            if (err_done) begin
                // A coinciding clear still records this error, leaving a count of one.
                err_addr_q  <= haddr_q;
                err_write_q <= hwrite_q;
                if (ERR_CLR) begin
                    err_cnt_q <= ERR_CNT_WIDTH'(1);
                end else if (!(&err_cnt_q)) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
                end
            end else if (ERR_CLR) begin
                err_addr_q  <= '0;
                err_write_q <= 1'b0;
                err_cnt_q   <= '0;
            end
        end
    end

    assign bus.HSEL_S   = hsel;
    assign bus.HRDATA   = hrdata;
    assign bus.HRESP    = hresp;
    assign bus.HREADY   = hready;
    assign bus.HREADY_S = hready;

    assign ERR_ADDR  = err_addr_q;
    assign ERR_WRITE = err_write_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_ahb_lite_matrix.sv
// Directed bench for ahb_lite_matrix with ERR_CNT_WIDTH=2 so saturation is reachable.
module tb_ahb_lite_matrix;

    logic        HCLK;
    logic        HRESET;
    logic        ERR_CLR;
    logic [31:0] ERR_ADDR;
    logic        ERR_WRITE;
    logic [1:0]  ERR_CNT;

    int checks;
    int errors;

    ahb_lite_matrix_if #(
        .NO_OF_SUBORDINATES (4),
        .ADDR_WIDTH         (32),
        .DATA_WIDTH         (32)
    ) bus ();

    ahb_lite_matrix #(
        .NO_OF_SUBORDINATES (4),
        .ADDR_WIDTH         (32),
        .DATA_WIDTH         (32),
        .ERR_CNT_WIDTH      (2)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus),
        .ERR_CLR   (ERR_CLR),
        .ERR_ADDR  (ERR_ADDR),
        .ERR_WRITE (ERR_WRITE),
        .ERR_CNT   (ERR_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        ERR_CLR = 1'b0;
        bus.HADDR = 32'h0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HRDATA_S = '0;
        bus.HRESP_S = '0;
        bus.HREADYOUT_S = 4'hF;
        step();
        step();
        HRESET = 1'b0;
        #1;
        checks++; if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready got %0h want 1", bus.HREADY); end
        checks++; if (bus.HRESP !== 2'b00) begin errors++; $display("FAIL reset_hresp got %0h want 0", bus.HRESP); end
        checks++; if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h want 0", bus.HRDATA); end
        checks++; if (ERR_CNT !== 2'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", ERR_CNT); end
        checks++; if (ERR_ADDR !== 32'h0) begin errors++; $display("FAIL reset_erraddr got %h want 0", ERR_ADDR); end
        // Start an unmapped NONSEQ, then reset in the middle of its ERR1 cycle.
        bus.HADDR = 32'h5000_0000;
        bus.HTRANS = 2'b10;
        step();
        bus.HTRANS = 2'b00;
        #1;
        checks++; if (bus.HREADY !== 1'b0) begin errors++; $display("FAIL midreset_err1_hready got %0h want 0", bus.HREADY); end
        HRESET = 1'b1;
        #1;
        checks++; if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL midreset_hready got %0h want 1", bus.HREADY); end
        checks++; if (bus.HRESP !== 2'b00) begin errors++; $display("FAIL midreset_hresp got %0h want 0", bus.HRESP); end
        checks++; if (ERR_CNT !== 2'd0) begin errors++; $display("FAIL midreset_errcnt got %0d want 0", ERR_CNT); end
        step();
        HRESET = 1'b0;
        step();
        checks++; if (ERR_CNT !== 2'd0) begin errors++; $display("FAIL postreset_errcnt got %0d want 0", ERR_CNT); end
    endtask

    task automatic test_decode();
        logic [31:0] addrs [6];
        logic [3:0]  sels  [6];
        addrs = '{32'h0000_0000, 32'h0FFF_FFFC, 32'h1000_0000, 32'h3FFF_FFFC,
                  32'h4000_0000, 32'hF000_0000};
        sels  = '{4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
        bus.HTRANS = 2'b00;
        for (int i = 0; i < 6; i++) begin
            bus.HADDR = addrs[i];
            #1;
            checks++; if (bus.HSEL_S !== sels[i]) begin errors++; $display("FAIL decode_%0d got %b want %b", i, bus.HSEL_S, sels[i]); end
        end
        step();
    endtask

    task automatic test_mapped_read();
        bus.HADDR = 32'h2000_0010;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        #1;
        checks++; if (bus.HSEL_S !== 4'b0100) begin errors++; $display("FAIL read_hsel got %b want 0100", bus.HSEL_S); end
        step();
        bus.HADDR = 32'h0;
        bus.HTRANS = 2'b00;
        bus.HRDATA_S = {32'h3333_3333, 32'hA5A5_0001, 32'hDEAD_BEEF, 32'h0000_1111};
        #1;
        checks++; if (bus.HRDATA !== 32'hA5A5_0001) begin errors++; $display("FAIL read_hrdata got %h want a5a50001", bus.HRDATA); end
        checks++; if (bus.HRESP !== 2'b00) begin errors++; $display("FAIL read_hresp got %0h want 0", bus.HRESP); end
        checks++; if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL read_hready got %0h want 1", bus.HREADY); end
        step();
    endtask

    task automatic test_wait_states();
        bus.HADDR = 32'h1000_0004;
        bus.HTRANS = 2'b10;
        #1;
        checks++; if (bus.HSEL_S !== 4'b0010) begin errors++; $display("FAIL wait_hsel got %b want 0010", bus.HSEL_S); end
        step();
        bus.HADDR = 32'h5000_0000;
        bus.HREADYOUT_S = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.HREADY !== 1'b0) begin errors++; $display("FAIL wait_stall_%0d got %0h want 0", k, bus.HREADY); end
            step();
        end
        bus.HREADYOUT_S = 4'hF;
        bus.HRDATA_S = {32'h3333_3333, 32'h2222_2222, 32'h1111_2222, 32'h0000_1111};
        #1;
        checks++; if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL wait_done_hready got %0h want 1", bus.HREADY); end
        checks++; if (bus.HRDATA !== 32'h1111_2222) begin errors++; $display("FAIL wait_owner_hrdata got %h want 11112222", bus.HRDATA); end
        step();
        bus.HTRANS = 2'b00;
        bus.HADDR = 32'h0;
        #1;
        checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL wait_err1 got ready=%0h resp=%0h want ready=0 resp=1", bus.HREADY, bus.HRESP); end
        step();
        checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL wait_err2 got ready=%0h resp=%0h want ready=1 resp=1", bus.HREADY, bus.HRESP); end
        step();
        checks++; if (bus.HRESP !== 2'b00) begin errors++; $display("FAIL wait_after_hresp got %0h want 0", bus.HRESP); end
        checks++; if (ERR_CNT !== 2'd1) begin errors++; $display("FAIL wait_errcnt got %0d want 1", ERR_CNT); end
        checks++; if (ERR_ADDR !== 32'h5000_0000) begin errors++; $display("FAIL wait_erraddr got %h want 50000000", ERR_ADDR); end
        checks++; if (ERR_WRITE !== 1'b0) begin errors++; $display("FAIL wait_errwrite got %0h want 0", ERR_WRITE); end
    endtask

    task automatic test_back_to_back();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        checks++; if (ERR_CNT !== 2'd0 || ERR_ADDR !== 32'h0) begin errors++; $display("FAIL clear got cnt=%0d addr=%h want cnt=0 addr=0", ERR_CNT, ERR_ADDR); end
        bus.HADDR = 32'h8000_0000;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        step();
        bus.HADDR = 32'h8000_0004;
        bus.HTRANS = 2'b11;
        #1;
        checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL b2b_c0 got ready=%0h resp=%0h want ready=0 resp=1", bus.HREADY, bus.HRESP); end
        step();
        checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL b2b_c1 got ready=%0h resp=%0h want ready=1 resp=1", bus.HREADY, bus.HRESP); end
        step();
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR = 32'h0;
        #1;
        checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL b2b_c2 got ready=%0h resp=%0h want ready=0 resp=1", bus.HREADY, bus.HRESP); end
        checks++; if (ERR_CNT !== 2'd1 || ERR_ADDR !== 32'h8000_0000) begin errors++; $display("FAIL b2b_first got cnt=%0d addr=%h want cnt=1 addr=80000000", ERR_CNT, ERR_ADDR); end
        step();
        checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL b2b_c3 got ready=%0h resp=%0h want ready=1 resp=1", bus.HREADY, bus.HRESP); end
        step();
        checks++; if (ERR_ADDR !== 32'h8000_0004) begin errors++; $display("FAIL b2b_erraddr got %h want 80000004", ERR_ADDR); end
        checks++; if (ERR_WRITE !== 1'b1) begin errors++; $display("FAIL b2b_errwrite got %0h want 1", ERR_WRITE); end
        checks++; if (ERR_CNT !== 2'd2) begin errors++; $display("FAIL b2b_errcnt got %0d want 2", ERR_CNT); end
        checks++; if (bus.HRESP !== 2'b00) begin errors++; $display("FAIL b2b_idle_hresp got %0h want 0", bus.HRESP); end
    endtask

    task automatic test_idle_unmapped();
        bus.HADDR = 32'hF000_0000;
        bus.HTRANS = 2'b00;
        #1;
        checks++; if (bus.HSEL_S !== 4'b0000) begin errors++; $display("FAIL idle_hsel got %b want 0000", bus.HSEL_S); end
        step();
        bus.HTRANS = 2'b01;
        #1;
        checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 2'b00) begin errors++; $display("FAIL idle_resp got ready=%0h resp=%0h want ready=1 resp=0", bus.HREADY, bus.HRESP); end
        step();
        bus.HTRANS = 2'b00;
        #1;
        checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 2'b00) begin errors++; $display("FAIL busy_resp got ready=%0h resp=%0h want ready=1 resp=0", bus.HREADY, bus.HRESP); end
        step();
        checks++; if (ERR_CNT !== 2'd2) begin errors++; $display("FAIL idle_errcnt got %0d want 2", ERR_CNT); end
    endtask

    task automatic test_saturation_clear();
        int exp_cnt;
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.HADDR = 32'h9000_0000 + 32'(k * 4);
            bus.HTRANS = 2'b10;
            bus.HWRITE = 1'b0;
            step();
            bus.HTRANS = 2'b00;
            step();
            step();
            exp_cnt = (k + 1 < 3) ? k + 1 : 3;
            checks++; if (ERR_CNT !== 2'(exp_cnt)) begin errors++; $display("FAIL sat_%0d got %0d want %0d", k, ERR_CNT, exp_cnt); end
        end
        bus.HADDR = 32'hA000_0040;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        step();
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        step();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        checks++; if (ERR_CNT !== 2'd1) begin errors++; $display("FAIL clr_collide_cnt got %0d want 1", ERR_CNT); end
        checks++; if (ERR_ADDR !== 32'hA000_0040) begin errors++; $display("FAIL clr_collide_addr got %h want a0000040", ERR_ADDR); end
        checks++; if (ERR_WRITE !== 1'b1) begin errors++; $display("FAIL clr_collide_write got %0h want 1", ERR_WRITE); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decode();
        test_mapped_read();
        test_wait_states();
        test_back_to_back();
        test_idle_unmapped();
        test_saturation_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_matrix.md
Name: ahb_lite_matrix

Overview:
- Parametrised single-manager AHB-Lite interconnect core. Decodes the address phase against a per-subordinate region table and drives NO_OF_SUBORDINATES select lines.
- Registers the data-phase owner and uses it to multiplex HRDATA/HRESP/HREADY back to the manager.
- Contains an integrated default subordinate that gives the two-cycle ERROR response for unmapped addresses, plus sticky error-capture registers.
- Replaces the fixed three-subordinate decoder/mux/default-slave set; the subordinate memories stay external.

Parameters:
- NO_OF_SUBORDINATES, 4, number of external subordinates (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- SUB_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed NO_OF_SUBORDINATES*ADDR_WIDTH region bases; index 0 is in the LSBs.
- SUB_MASK, {4{32'hF000_0000}}, packed region masks; region i matches when (HADDR & mask_i) == base_i.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- HCLK  input  1  clock.
- HRESET  input  1  reset; asynchronous, active-high.
- HADDR  input  ADDR_WIDTH  manager address.
- HTRANS  input  2  manager transfer type.
- HWRITE  input  1  manager direction.
- HSEL_S  output  NO_OF_SUBORDINATES  one-hot address-phase selects.
- HREADY_S  output  1  HREADY fed back to all subordinates (equals HREADY).
- HRDATA_S  input  NO_OF_SUBORDINATES*DATA_WIDTH  subordinate read data.
- HRESP_S  input  NO_OF_SUBORDINATES*2  subordinate responses.
- HREADYOUT_S  input  NO_OF_SUBORDINATES  subordinate ready outputs.
- HRDATA  output  DATA_WIDTH  muxed read data to manager.
- HRESP  output  2  muxed response; 2'b00 OKAY, 2'b01 ERROR.
- HREADY  output  1  muxed ready to manager.
- ERR_CLR  input  1  synchronous clear of the error capture registers.
- ERR_ADDR  output  ADDR_WIDTH  address of the most recent errored transfer.
- ERR_WRITE  output  1  HWRITE of the most recent errored transfer.
- ERR_CNT  output  ERR_CNT_WIDTH  saturating count of ERROR completions.

Behaviour:
- Decode (combinational):
  - Region i hits when the masked compare matches. On overlap, the lowest index wins.
  - HSEL_S is one-hot or zero. No hit selects the default subordinate; HSEL_S is then all-zero.
- Data-phase owner:
  - Register dsel (NO_OF_SUBORDINATES+1 states, including DEFAULT) loads the decode result on posedge HCLK when HREADY==1.
  - When HREADY==0, dsel holds.
  - Reset value is DEFAULT.
- Output mux:
  - HRDATA/HRESP/HREADY come from subordinate dsel.
  - When dsel is DEFAULT, the outputs come from the default subordinate.
  - There is no combinational path from HADDR to HRDATA.
- Default subordinate FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=OKAY, HRDATA=0.
    - HREADY==1 and a default decode with HTRANS[1]==1 (NONSEQ/SEQ) -> ERR1.
    - IDLE/BUSY transfers stay in IDLE and get a zero-wait OKAY.
  - ERR1: HREADY=0, HRESP=ERROR; go to ERR2 unconditionally.
  - ERR2: HREADY=1, HRESP=ERROR.
    - Next is ERR1 if another qualifying unmapped transfer is sampled, else IDLE.
  - ERR1/ERR2 outputs drive the manager only while dsel==DEFAULT.
- Error capture:
  - On the cycle any ERROR completes (HREADY==1 && HRESP==ERROR, from any source), latch the data-phase address and write registers into ERR_ADDR/ERR_WRITE.
  - On the same cycle, increment ERR_CNT; it saturates at all-ones.
  - The data-phase address/write registers load HADDR/HWRITE when HREADY==1.
  - ERR_CLR zeroes ERR_ADDR, ERR_WRITE and ERR_CNT. If ERR_CLR coincides with an ERROR completion, the capture wins and ERR_CNT becomes 1.
- Subordinate wait states: HREADY low from the selected subordinate stalls the bus. dsel, the address registers and the FSM hold.
- Reset values:
  - HREADY=1, HRESP=OKAY, HRDATA=0.
  - ERR_ADDR=0, ERR_WRITE=0, ERR_CNT=0.
  - FSM=IDLE, dsel=DEFAULT.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous assertion). Any in-flight transfer is abandoned without a response.
- Latency: zero-wait OKAY for mapped subordinates that are ready. Unmapped NONSEQ/SEQ takes exactly 2 data-phase cycles.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP encodings (OKAY/ERROR).
  - The default-subordinate FSM state enum.
  - A function decoding HADDR against SUB_BASE/SUB_MASK.
- One sub-module, ahb_lite_default_sub: the ERR1/ERR2 FSM. Error capture and mux stay in the top.

Test Plan:
- Reset: HRESET=1 mid-NONSEQ -> HREADY=1, HRESP=00, ERR_CNT=0, dsel=DEFAULT on the same cycle.
- Mapped read: NONSEQ read 0x2000_0010, subordinate 2 drives HRDATA_S=0xA5A5_0001 with HREADYOUT_S[2]=1 -> HSEL_S=4'b0100 in the address phase; next cycle HRDATA=0xA5A5_0001, HRESP=00.
- Wait states: subordinate 1 holds HREADYOUT low 3 cycles on 0x1000_0004 while the next address is 0x5000_0000 -> HREADY low 3 cycles; dsel stays 1 until completion; then the unmapped transfer gets ERR1/ERR2.
- Unmapped back-to-back: NONSEQ write 0x8000_0000 then SEQ 0x8000_0004 -> HREADY 0,1,0,1 with HRESP=01 throughout; ERR_ADDR=0x8000_0004, ERR_WRITE=1, ERR_CNT=2.
- IDLE to unmapped address: HTRANS=IDLE, HADDR=0xF000_0000 -> zero-wait OKAY; ERR_CNT unchanged.
- Saturation/clear: ERR_CNT_WIDTH=2, 5 errors -> ERR_CNT=3. ERR_CLR asserted together with a 6th ERROR completion -> ERR_CNT=1.
